// File: rtl/clk_ena_monitor.sv
// Receive-side checker for the sys_clk enable bundle: tracks a 16-phase reference,
// locks onto sym_clk_ena and counts cadence errors. Optional macro: CLK_MON_PHASE_CHECK_EN.
//   state     | meaning
//   S_SEARCH  | waiting for sym_clk_ena, reference held at 0, no checks
//   S_ACQUIRE | counting clean periods; any error restarts the search
//   S_LOCKED  | locked; drops after LOSS_COUNT consecutive errored periods
module clk_ena_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clock_12_5_ena,
  input  logic             sam_clk_ena,
  input  logic             sym_clk_ena,
  input  logic [3:0]       clk_phase,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       exp_phase
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {S_SEARCH, S_ACQUIRE, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic             per_err_q, per_err_d;
  logic             locked_q, pulse_q;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             phase_bad, cyc_err, period_end;

`ifdef CLK_MON_PHASE_CHECK_EN
  assign phase_bad = (clk_phase != phase_q);
`else
  logic unused_clk_phase;
  assign unused_clk_phase = ^clk_phase;
  assign phase_bad = 1'b0;
`endif

  assign period_end = (phase_q == 4'd15);

  always_comb begin
    cyc_err   = 1'b0;
    state_d   = state_q;
    phase_d   = phase_q;
    good_d    = good_q;
    bad_d     = bad_q;
    per_err_d = per_err_q;
    if (state_q != S_SEARCH) begin
      cyc_err = (clock_12_5_ena != phase_q[0])
              | (sam_clk_ena != (phase_q[1:0] == 2'd3))
              | (sym_clk_ena != period_end)
              | phase_bad;
    end
    case (state_q)
      S_SEARCH: begin
        phase_d   = 4'd0;
        per_err_d = 1'b0;
        if (sym_clk_ena) begin
          state_d = S_ACQUIRE;
          good_d  = 4'd0;
        end
      end
      S_ACQUIRE: begin
        phase_d   = phase_q + 4'd1;
        per_err_d = 1'b0;
        if (cyc_err) begin
          state_d = S_SEARCH;
          phase_d = 4'd0;
        end else if (period_end) begin
          good_d = good_q + 4'd1;
          if (good_d == LOCK_N) begin
            state_d = S_LOCKED;
            bad_d   = 4'd0;
          end
        end
      end
      S_LOCKED: begin
        phase_d   = phase_q + 4'd1;
        per_err_d = per_err_q | cyc_err;
        // Lock only reacts at period boundaries, never to a single error.
        if (period_end) begin
          per_err_d = 1'b0;
          if (per_err_q | cyc_err) begin
            bad_d = bad_q + 4'd1;
            if (bad_d == LOSS_N) begin
              state_d = S_SEARCH;
              phase_d = 4'd0;
            end
          end else begin
            bad_d = 4'd0;
          end
        end
      end
      default: begin
        state_d = S_SEARCH;
        phase_d = 4'd0;
      end
    endcase

    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = '0;
    else if (cyc_err && (cnt_q != '1))
      cnt_d = cnt_q + ERR_W'(1);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_SEARCH;
      phase_q   <= 4'd0;
      good_q    <= 4'd0;
      bad_q     <= 4'd0;
      per_err_q <= 1'b0;
      locked_q  <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      per_err_q <= per_err_d;
      locked_q  <= (state_d == S_LOCKED);
      pulse_q   <= cyc_err;
      cnt_q     <= cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;
  assign exp_phase = phase_q;

endmodule

// File: tb/tb_clk_ena_monitor.sv
// Scoreboard bench for clk_ena_monitor: the driver queues hand-computed expectations
// keyed by cycle number, a negedge monitor pops and compares them.
module tb_clk_ena_monitor;
  localparam int ERR_W = 4;

  logic             sys_clk = 1'b0;
  logic             reset = 1'b1;
  logic             clock_12_5_ena = 1'b0, sam_clk_ena = 1'b0, sym_clk_ena = 1'b0;
  logic [3:0]       clk_phase = 4'd0;
  logic             err_clr = 1'b0;
  logic             locked, err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       exp_phase;

  clk_ena_monitor #(.LOCK_COUNT(4), .LOSS_COUNT(2), .ERR_W(ERR_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .clock_12_5_ena(clock_12_5_ena),
    .sam_clk_ena(sam_clk_ena), .sym_clk_ena(sym_clk_ena), .clk_phase(clk_phase),
    .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .exp_phase(exp_phase));

  always #5 sys_clk = ~sys_clk;

  typedef enum int {F_LOCK, F_PULSE, F_CNT, F_PHASE, F_NPULSE} fld_t;
  typedef struct {int cyc; fld_t f; int val; string name;} exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0, cyc = -1, pulse_seen = 0;
  logic [3:0] ph = 4'd0;
  logic glitch_sam = 0, extra_sym = 0, inv_half = 0, stuck_phase = 0;

`ifdef CLK_MON_PHASE_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  task automatic expect_at(input int c, input fld_t f, input int v, input string n);
    exp_t e;
    int i;
    e.cyc = c; e.f = f; e.val = v; e.name = n;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    logic [31:0] act;
    if (err_pulse === 1'b1) pulse_seen++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.f)
        F_LOCK:  act = 32'(locked);
        F_PULSE: act = 32'(err_pulse);
        F_CNT:   act = 32'(err_count);
        F_PHASE: act = 32'(exp_phase);
        default: act = 32'(pulse_seen);
      endcase
      checks++;
      if (e.cyc != cyc || act !== 32'(e.val)) begin
        errors++;
        $display("FAIL %s @cycle %0d (seen at %0d): got %0d expected %0d",
                 e.name, e.cyc, cyc, act, e.val);
      end
    end
  end

  task automatic step();
    clock_12_5_ena = ph[0] ^ inv_half;
    sam_clk_ena    = (ph[1:0] == 2'd3) & ~glitch_sam;
    sym_clk_ena    = (ph == 4'd15) | extra_sym;
    clk_phase      = stuck_phase ? 4'd5 : ph;
    @(posedge sys_clk);
    #1;
    cyc++;
    ph = ph + 4'd1;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic sam_glitch_at(input int c);
    run_until(c);
    glitch_sam = 1'b1;
    step();
    glitch_sam = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    ph = 4'd0;

    // clean acquisition, first sym_clk_ena at cycle 15
    expect_at(0, F_LOCK, 0, "rst_locked");
    expect_at(0, F_PULSE, 0, "rst_pulse");
    expect_at(0, F_CNT, 0, "rst_count");
    expect_at(0, F_PHASE, 0, "rst_phase");
    expect_at(10, F_PHASE, 0, "search_phase_held");
    expect_at(16, F_PHASE, 0, "acq_phase_start");
    expect_at(20, F_PHASE, 4, "acq_phase_run");
    expect_at(79, F_LOCK, 0, "lock_not_early");
    expect_at(80, F_LOCK, 1, "lock_at_80");
    expect_at(80, F_CNT, 0, "clean_count");
    expect_at(80, F_NPULSE, 0, "clean_no_pulse");
    run_until(100);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL direct_lock_100: got %0b expected 1", locked);
    end

    // single glitch while locked
    expect_at(115, F_PULSE, 0, "glitch_pulse_before");
    expect_at(116, F_PULSE, 1, "glitch_pulse");
    expect_at(116, F_CNT, 1, "glitch_count");
    expect_at(117, F_PULSE, 0, "glitch_pulse_after");
    expect_at(120, F_NPULSE, 1, "glitch_one_pulse");
    expect_at(130, F_LOCK, 1, "glitch_lock_kept");
    expect_at(150, F_LOCK, 1, "glitch_lock_kept2");
    sam_glitch_at(115);

    // lock loss after two consecutive errored periods, then relock
    expect_at(164, F_CNT, 2, "loss_count1");
    expect_at(191, F_LOCK, 1, "loss_locked_at_end");
    expect_at(192, F_LOCK, 0, "loss_unlocked");
    expect_at(192, F_CNT, 3, "loss_count2");
    expect_at(193, F_PHASE, 0, "loss_search_phase");
    expect_at(208, F_PHASE, 0, "reacq_phase0");
    expect_at(209, F_PHASE, 1, "reacq_phase1");
    expect_at(271, F_LOCK, 0, "relock_not_early");
    expect_at(272, F_LOCK, 1, "relock");
    sam_glitch_at(163);
    sam_glitch_at(179);

    // second lock loss, err_clr, then an error during acquisition
    expect_at(320, F_LOCK, 0, "loss2_unlocked");
    expect_at(325, F_CNT, 5, "pre_clr_count");
    expect_at(326, F_CNT, 0, "clr_count");
    expect_at(344, F_LOCK, 0, "acqerr_unlocked");
    expect_at(344, F_PULSE, 1, "acqerr_pulse");
    expect_at(344, F_CNT, 1, "acqerr_count");
    expect_at(345, F_PHASE, 0, "acqerr_search");
    expect_at(352, F_PHASE, 0, "acqerr_reacq");
    expect_at(415, F_LOCK, 0, "acqerr_relock_not_early");
    expect_at(416, F_LOCK, 1, "acqerr_relock");
    sam_glitch_at(291);
    sam_glitch_at(307);
    run_until(325);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    run_until(343);
    extra_sym = 1'b1;
    step();
    extra_sym = 1'b0;

    // saturation with continuous errors, err_clr against a simultaneous error
    expect_at(440, F_CNT, 9, "sat_climb");
    expect_at(446, F_CNT, 15, "sat_reached");
    expect_at(447, F_CNT, 15, "sat_hold");
    expect_at(448, F_CNT, 0, "clr_beats_error");
    expect_at(464, F_LOCK, 1, "sat_lock_kept");
    run_until(432);
    inv_half = 1'b1;
    run_until(447);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    inv_half = 1'b0;

    // clk_phase stuck at 5 with correct enables
    expect_at(480, F_CNT, PCHK ? 15 : 0, "phase_fault_count");
    expect_at(495, F_LOCK, 1, "phase_fault_lock_end");
    expect_at(496, F_LOCK, PCHK ? 0 : 1, "phase_fault_lock");
    expect_at(500, F_PULSE, PCHK ? 0 : 1, "search_no_check_pulse");
    expect_at(500, F_CNT, PCHK ? 15 : 1, "search_no_check_count");
    expect_at(576, F_LOCK, 1, "locked_before_reset");
    run_until(464);
    stuck_phase = 1'b1;
    run_until(496);
    stuck_phase = 1'b0;
    sam_glitch_at(499);

    // reset mid-LOCKED, with a pending error pulse
    expect_at(579, F_LOCK, 1, "pre_reset_locked");
    expect_at(579, F_PHASE, 3, "pre_reset_phase");
    expect_at(580, F_LOCK, 0, "reset_locked");
    expect_at(580, F_PULSE, 0, "reset_pulse");
    expect_at(580, F_CNT, 0, "reset_count");
    expect_at(580, F_PHASE, 0, "reset_phase");
    expect_at(585, F_PHASE, 0, "post_reset_search");
    expect_at(592, F_PHASE, 0, "post_reset_acq0");
    expect_at(596, F_PHASE, 4, "post_reset_acq4");
    expect_at(598, F_LOCK, 0, "post_reset_unlocked");
    sam_glitch_at(579);
    reset = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL direct_reset_locked: got %0b expected 0", locked);
    end
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL direct_reset_pulse: got %0b expected 0", err_pulse);
    end
    checks++;
    if (err_count !== '0) begin
      errors++;
      $display("FAIL direct_reset_count: got %0d expected 0", err_count);
    end
    checks++;
    if (exp_phase !== 4'd0) begin
      errors++;
      $display("FAIL direct_reset_phase: got %0d expected 0", exp_phase);
    end
    run_until(583);
    reset = 1'b0;
    run_until(600);
    @(negedge sys_clk);
    #1;

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s @cycle %0d: never compared, expected %0d", e.name, e.cyc, e.val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
